// File: rtl/rom_arbiter_pkg.sv
// rtl/rom_arbiter_pkg.sv - shared constants for the program ROM arbiter
// Port indices and default ROM geometry shared with the ROM and core.
package rom_arbiter_pkg;

  localparam int PORT_FETCH = 0;
  localparam int PORT_SCAN  = 1;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 8;

  // One-hot winner encoding; bit index matches the port index constants.
  typedef enum logic [1:0] {
    WIN_NONE  = 2'b00,
    WIN_FETCH = 2'b01,
    WIN_SCAN  = 2'b10
  } win_e;

endpackage

// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - two-port program ROM arbiter with bounded scanner lock
// Fetch (port 0) and bracket scan (port 1) share one synchronous-read ROM.
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int LOCK_MAX   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  output logic                  gnt0,
  output logic                  rvalid0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic                  lock1,
  output logic                  gnt1,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  rom_ren,
  output logic [ADDR_WIDTH-1:0] rom_raddr,
  input  logic [DATA_WIDTH-1:0] rom_rdata
);

  localparam int              CNT_W      = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] LOCK_LIMIT = CNT_W'(LOCK_MAX);

  logic                  last_q, last_d;
  logic                  locked_q, locked_d;
  logic [CNT_W-1:0]      lock_cnt_q, lock_cnt_d;
  logic [1:0]            pend_q, pend_d;
  logic [DATA_WIDTH-1:0] hold0_q, hold0_d;
  logic [DATA_WIDTH-1:0] hold1_q, hold1_d;

  win_e       win;
  logic [1:0] gnt_vec;

  // A held lock only yields once it has run LOCK_MAX grants and fetch is waiting.
  always_comb begin
    win = WIN_NONE;
    if (locked_q && req1 && ((lock_cnt_q < LOCK_LIMIT) || !req0)) begin
      win = WIN_SCAN;
    end else if (req0 && !req1) begin
      win = WIN_FETCH;
    end else if (req1 && !req0) begin
      win = WIN_SCAN;
    end else if (req0 && req1) begin
      win = last_q ? WIN_FETCH : WIN_SCAN;
    end
    if (rst) begin
      win = WIN_NONE;
    end
  end

  assign gnt_vec   = win;
  assign gnt0      = gnt_vec[PORT_FETCH];
  assign gnt1      = gnt_vec[PORT_SCAN];
  assign rom_ren   = gnt0 | gnt1;
  assign rom_raddr = gnt1 ? addr1 : addr0;

  always_comb begin
    last_d     = last_q;
    locked_d   = gnt1 & lock1;
    lock_cnt_d = '0;
    pend_d     = gnt_vec;
    hold0_d    = hold0_q;
    hold1_d    = hold1_q;

    if (gnt1) begin
      last_d = 1'b1;
    end else if (gnt0) begin
      last_d = 1'b0;
    end

    if (gnt1) begin
      if (!locked_q) begin
        lock_cnt_d = CNT_W'(1);
      end else if (lock_cnt_q == LOCK_LIMIT) begin
        lock_cnt_d = lock_cnt_q;
      end else begin
        lock_cnt_d = lock_cnt_q + CNT_W'(1);
      end
    end

    if (pend_q[PORT_FETCH]) begin
      hold0_d = rom_rdata;
    end
    if (pend_q[PORT_SCAN]) begin
      hold1_d = rom_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q     <= 1'b1;
      locked_q   <= 1'b0;
      lock_cnt_q <= '0;
      pend_q     <= 2'b00;
      hold0_q    <= '0;
      hold1_q    <= '0;
    end else begin
      last_q     <= last_d;
      locked_q   <= locked_d;
      lock_cnt_q <= lock_cnt_d;
      pend_q     <= pend_d;
      hold0_q    <= hold0_d;
      hold1_q    <= hold1_d;
    end
  end

  // Returning data bypasses the hold register in its valid cycle.
  assign rvalid0 = pend_q[PORT_FETCH];
  assign rvalid1 = pend_q[PORT_SCAN];
  assign rdata0  = pend_q[PORT_FETCH] ? rom_rdata : hold0_q;
  assign rdata1  = pend_q[PORT_SCAN]  ? rom_rdata : hold1_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// tb/tb_rom_arbiter.sv - self-checking bench for rom_arbiter
// Grant vectors from a table; read returns checked through a scoreboard queue.
module tb_rom_arbiter;

  localparam int DW = 8;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, lock1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, rom_ren;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] rom_raddr;
  logic [DW-1:0] rom_rdata = '0;

  rom_arbiter #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .LOCK_MAX  (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .addr0    (addr0),
    .gnt0     (gnt0),
    .rvalid0  (rvalid0),
    .rdata0   (rdata0),
    .req1     (req1),
    .addr1    (addr1),
    .lock1    (lock1),
    .gnt1     (gnt1),
    .rvalid1  (rvalid1),
    .rdata1   (rdata1),
    .rom_ren  (rom_ren),
    .rom_raddr(rom_raddr),
    .rom_rdata(rom_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_val(input logic [AW-1:0] a);
    if (a == 8'h05) return 8'h2B;
    return 8'(a * 8'd37 + 8'd11);
  endfunction

  always @(posedge clk) begin
    if (rom_ren) rom_rdata <= rom_val(rom_raddr);
  end

  typedef struct {
    logic          rst;
    logic          req0;
    logic          req1;
    logic          lock1;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [1:0]    eg;
  } vec_t;

  typedef struct {
    logic          port;
    logic [DW-1:0] data;
    int            due;
  } ret_t;

  vec_t          vecs[$];
  ret_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic [DW-1:0] hold0_m = '0;
  logic [DW-1:0] hold1_m = '0;

  task automatic add(input logic r, input logic q0, input logic q1, input logic l,
                     input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                     input logic [1:0] eg);
    vec_t v;
    v.rst = r; v.req0 = q0; v.req1 = q1; v.lock1 = l;
    v.a0 = a0; v.a1 = a1; v.eg = eg;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (step %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_ret();
    ret_t r;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      r = sb.pop_front();
      chk("rvalid0", 32'(rvalid0), 32'(r.port == 1'b0));
      chk("rvalid1", 32'(rvalid1), 32'(r.port == 1'b1));
      if (r.port) begin
        chk("rdata1", 32'(rdata1), 32'(r.data));
        chk("rdata0_hold", 32'(rdata0), 32'(hold0_m));
        hold1_m = r.data;
      end else begin
        chk("rdata0", 32'(rdata0), 32'(r.data));
        chk("rdata1_hold", 32'(rdata1), 32'(hold1_m));
        hold0_m = r.data;
      end
    end else begin
      chk("rvalid0_idle", 32'(rvalid0), 32'd0);
      chk("rvalid1_idle", 32'(rvalid1), 32'd0);
      chk("rdata0_hold", 32'(rdata0), 32'(hold0_m));
      chk("rdata1_hold", 32'(rdata1), 32'(hold1_m));
    end
  endtask

  initial begin
    ret_t r;
    logic [AW-1:0] exp_addr;

    // Reset, then single fetch of ROM[5], then idle steps.
    add(1, 0, 0, 0, 8'h00, 8'h00, 2'b00);
    add(1, 1, 1, 0, 8'h10, 8'h20, 2'b00);
    add(0, 0, 0, 0, 8'h00, 8'h00, 2'b00);
    add(0, 1, 0, 0, 8'h05, 8'h33, 2'b01);
    add(0, 0, 0, 0, 8'h07, 8'h09, 2'b00);
    add(0, 0, 0, 0, 8'h00, 8'h00, 2'b00);
    // Contention from reset: 0,1,0,1.
    add(1, 0, 0, 0, 8'h00, 8'h00, 2'b00);
    add(0, 1, 1, 0, 8'h11, 8'h81, 2'b01);
    add(0, 1, 1, 0, 8'h12, 8'h82, 2'b10);
    add(0, 1, 1, 0, 8'h13, 8'h83, 2'b01);
    add(0, 1, 1, 0, 8'h14, 8'h84, 2'b10);
    // Lock burst with LOCK_MAX=3, then plain round-robin.
    add(1, 0, 0, 0, 8'h00, 8'h00, 2'b00);
    add(0, 1, 1, 1, 8'h21, 8'h91, 2'b01);
    add(0, 1, 1, 1, 8'h22, 8'h92, 2'b10);
    add(0, 1, 1, 1, 8'h22, 8'h93, 2'b10);
    add(0, 1, 1, 1, 8'h22, 8'h94, 2'b10);
    add(0, 1, 1, 1, 8'h22, 8'h95, 2'b01);
    add(0, 1, 1, 0, 8'h23, 8'h96, 2'b10);
    add(0, 1, 1, 0, 8'h24, 8'h97, 2'b01);
    // Lock without contention: 20 scanner grants, no break.
    for (int i = 0; i < 20; i++) add(0, 0, 1, 1, 8'h00, 8'(8'hA0 + i), 2'b10);
    // Lock released when req1 drops, then round-robin.
    add(0, 1, 0, 1, 8'h31, 8'h00, 2'b01);
    add(0, 1, 1, 0, 8'h32, 8'hB1, 2'b10);
    add(0, 1, 1, 0, 8'h33, 8'hB2, 2'b01);
    add(0, 0, 1, 0, 8'h00, 8'hB3, 2'b10);
    // Reset while scanner requests: no grant, no rvalid, holds cleared.
    add(1, 0, 1, 0, 8'h00, 8'hC1, 2'b00);
    add(0, 0, 0, 0, 8'h00, 8'h00, 2'b00);
    add(0, 1, 1, 0, 8'h41, 8'hC2, 2'b01);
    add(0, 1, 1, 0, 8'h42, 8'hC2, 2'b10);
    add(0, 0, 0, 0, 8'h00, 8'h00, 2'b00);
    add(0, 0, 0, 0, 8'h00, 8'h00, 2'b00);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      check_ret();
      rst   = vecs[i].rst;
      req0  = vecs[i].req0;
      req1  = vecs[i].req1;
      lock1 = vecs[i].lock1;
      addr0 = vecs[i].a0;
      addr1 = vecs[i].a1;
      #1;
      chk("gnt0", 32'(gnt0), 32'(vecs[i].eg[0]));
      chk("gnt1", 32'(gnt1), 32'(vecs[i].eg[1]));
      chk("rom_ren", 32'(rom_ren), 32'(|vecs[i].eg));
      exp_addr = vecs[i].eg[1] ? vecs[i].a1 : vecs[i].a0;
      chk("rom_raddr", 32'(rom_raddr), 32'(exp_addr));
      if (vecs[i].eg[0]) begin
        r.port = 1'b0; r.data = rom_val(vecs[i].a0); r.due = cyc + 1;
        sb.push_back(r);
      end
      if (vecs[i].eg[1]) begin
        r.port = 1'b1; r.data = rom_val(vecs[i].a1); r.due = cyc + 1;
        sb.push_back(r);
      end
      if (vecs[i].rst) begin
        hold0_m = '0;
        hold1_m = '0;
      end
      cyc++;
    end
    @(negedge clk);
    check_ret();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Two-port arbiter that shares the single synchronous-read program ROM between the instruction fetch unit (port 0) and the bracket-scan unit (port 1). It decides one winner per cycle, drives the ROM read port, and returns read data to the winner one cycle later. A lock input lets the scanner hold the ROM for consecutive reads during a loop search, with a bounded hold length so fetch cannot starve.

## Interface
- DATA_WIDTH, 8, ROM word width
- ADDR_WIDTH, 8, ROM address width
- LOCK_MAX, 16, max consecutive locked grants to port 1 before port 0 is forced a slot (≥1)
- clk  in  1  system clock; one clock for the whole block
- rst  in  1  reset, synchronous, active-high
- req0  in  1  port 0 read request
- addr0  in  ADDR_WIDTH  port 0 read address
- gnt0  out  1  port 0 granted this cycle (combinational)
- rvalid0  out  1  port 0 read data valid (one-cycle pulse)
- rdata0  out  DATA_WIDTH  port 0 read data, held until next rvalid0
- req1  in  1  port 1 read request
- addr1  in  ADDR_WIDTH  port 1 read address
- lock1  in  1  port 1 requests to keep the grant next cycle
- gnt1  out  1  port 1 granted this cycle (combinational)
- rvalid1  out  1  port 1 read data valid
- rdata1  out  DATA_WIDTH  port 1 read data, held until next rvalid1
- rom_ren  out  1  ROM read enable
- rom_raddr  out  ADDR_WIDTH  ROM read address
- rom_rdata  in  DATA_WIDTH  ROM read data, valid the cycle after rom_ren

## Operation
- State: `last` (1 bit, last winner), `locked` (1 bit, port 1 won with lock1 high last cycle), `lock_cnt` (clog2(LOCK_MAX+1) bits), `pend[1:0]` (which port has data returning), `hold0`/`hold1` data registers.
- Each cycle, winner selection, in priority order:
  1. If `locked` and req1, and `lock_cnt < LOCK_MAX` or !req0, then port 1 wins.
  2. Else if only one port requests, that port wins.
  3. Else if both request, the port that is not `last` wins (round-robin).
- Winner: gntN=1, rom_ren=1, rom_raddr=addrN. With no requests, gnt0=gnt1=rom_ren=0 and rom_raddr=addr0 (don't-care, fixed for determinism).
- On a grant: `last` ← winner, `pend` ← one-hot winner. With no grant: `pend` ← 0 and `last` is unchanged.
- `locked` ← gnt1 & lock1.
- `lock_cnt`: incremented (saturating) on each port 1 grant while `locked`. Reset to 1 on a port 1 grant with !`locked`. Reset to 0 on any port 0 grant or idle cycle.
- Data return: in the cycle after a grant, rvalidN = pend[N] and rdataN = rom_rdata, and holdN captures rom_rdata. Outside rvalidN, rdataN = holdN.
- Back-to-back grants are allowed every cycle, alternating or repeating. Throughput is one read per cycle.
- Requesters keep reqN/addrN stable until gntN. A request dropped before its grant is simply not served. The block has no queue.

## Timing
- Grant is zero-latency (same cycle as req). Data latency is exactly 1 cycle after gnt.
- Reset (rst high at a clk edge): `last`=1 (port 0 favoured first), `locked`=0, `lock_cnt`=0, `pend`=0, hold0=hold1=0.
- While rst is high: gnt0, gnt1 and rom_ren are forced 0. rvalid0 and rvalid1 are 0 in the first cycle after rst deasserts.
- Reset mid-read: a read granted the cycle rst rises produces no rvalid.
- Simultaneous req0 & req1 from reset: port 0 wins first, then the ports alternate.
- Lock saturation: after LOCK_MAX consecutive locked port 1 grants with req0 pending, port 0 wins the next cycle. `locked` then clears because gnt1=0, so round-robin resumes.
- lock1 without req1 next cycle: the lock is released with no effect.

## Structure
- Shared package: port index constants (PORT_FETCH=0, PORT_SCAN=1) and the default DATA_WIDTH and ADDR_WIDTH values shared with the ROM and core.
- No sub-module is needed. Winner selection is a small combinational block beside the registers.
- The block instantiates nothing. The ROM is connected at the parent level.

## Test plan
- Single request: req0=1, addr0=0x05, ROM[5]=0x2B → gnt0 in the same cycle, rom_raddr=0x05, then rvalid0=1 and rdata0=0x2B one cycle later. rdata0 stays 0x2B afterwards.
- Contention from reset: req0 and req1 held high for 4 cycles → grant order 0,1,0,1. rvalid pulses follow one cycle behind in the same order.
- Lock burst: req0 and req1 held high, lock1=1, LOCK_MAX=3 → port 1 wins three consecutive cycles once it gains the lock. Port 0 wins the next cycle, then alternation resumes.
- Lock without contention: req1=lock1=1 for 20 cycles, req0=0 → port 1 is granted all 20 cycles, with no forced break.
- Reset mid-operation: grant port 1 at cycle T and assert rst at T → no rvalid1 at T+1. After release, hold1=0 and the first contention goes to port 0.
- Idle: no requests → rom_ren=0, gnt=0, rvalid=0, and holds are unchanged.
